// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between NUM_REQ byte-stream sources using
// packet-level round-robin arbitration.  The granted source keeps the UART
// until its last byte has finished on the line, or until it drops req, or
// until MAX_PKT_BYTES bytes have been sent.  The search pointer then moves
// to the source after the one that was granted.
//
// Only one byte is ever in flight.  A byte is accepted in WAIT_BYTE, started
// in START once the UART is idle, and its completion is observed in
// WAIT_BUSY and WAIT_DONE.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a granted source that presents no byte for TIMEOUT_CYCLES
//   cycles is released, and timeout_pulse fires for one cycle.  When it is
//   undefined, timeout_pulse is tied low and no counter exists.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   req            per-source packet request, held for the whole packet
//   src_valid      per-source byte valid
//   src_data       per-source byte, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_last       per-source "final byte of packet"
//   src_ready      one-hot byte accept for the granted source
//   grant          one-hot current owner, 0 when idle
//   uart_tx_start  one-cycle start pulse to uart_tx
//   uart_tx_data   byte to uart_tx, held until the next accepted byte
//   uart_tx_busy   uart_tx busy
//   arb_busy       grant != 0
//   pkt_done       one-cycle pulse after the last byte of a packet completes
//   timeout_pulse  one-cycle pulse on forced release (ARB_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_REQ        = 3,
   parameter int MAX_PKT_BYTES  = 64,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            src_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
   input  logic [NUM_REQ-1:0]            src_last,
   output logic [NUM_REQ-1:0]            src_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          uart_tx_start,
   output logic [DATA_WIDTH-1:0]         uart_tx_data,
   input  logic                          uart_tx_busy,
   output logic                          arb_busy,
   output logic                          pkt_done,
   output logic                          timeout_pulse
);

   // Index width covers the supported 2..4 requesters.
   localparam int IDX_W = 2;

   // byte_cnt width = clog2(MAX_PKT_BYTES) + 1.
   localparam int MAX_LOG2 =
      (MAX_PKT_BYTES <= 1)    ? 0  : (MAX_PKT_BYTES <= 2)    ? 1  :
      (MAX_PKT_BYTES <= 4)    ? 2  : (MAX_PKT_BYTES <= 8)    ? 3  :
      (MAX_PKT_BYTES <= 16)   ? 4  : (MAX_PKT_BYTES <= 32)   ? 5  :
      (MAX_PKT_BYTES <= 64)   ? 6  : (MAX_PKT_BYTES <= 128)  ? 7  :
      (MAX_PKT_BYTES <= 256)  ? 8  : (MAX_PKT_BYTES <= 512)  ? 9  :
      (MAX_PKT_BYTES <= 1024) ? 10 : (MAX_PKT_BYTES <= 2048) ? 11 :
      (MAX_PKT_BYTES <= 4096) ? 12 : 13;
   localparam int CNT_W = MAX_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BYTES - 1);

   if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_PKT_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("uart_tx_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]        gidx_q, gidx_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic                    last_q, last_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [1:0]              wb_cnt_q, wb_cnt_d;
   logic                    start_q, start_d;
   logic                    done_q, done_d;
   logic [NUM_REQ-1:0]      ready_q, ready_d;
   logic                    arb_busy_q, arb_busy_d;

   // Per-source byte lanes.
   logic [DATA_WIDTH-1:0]   src_byte [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign src_byte[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // (base + k) mod NUM_REQ for k in 0..NUM_REQ.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[IDX_W-1:0];
   endfunction

   // Round-robin search starting at rr_ptr, plus the granted source's lane.
   logic                    found;
   logic [IDX_W-1:0]        pick;
   logic                    sel_valid;
   logic                    sel_last;
   logic                    sel_req;
   logic [DATA_WIDTH-1:0]   sel_data;

   always_comb begin
      found     = 1'b0;
      pick      = rr_ptr_q;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_req   = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (IDX_W'(j) == wrap_add(rr_ptr_q, k))) begin
               found = 1'b1;
               pick  = IDX_W'(j);
            end
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (IDX_W'(j) == gidx_q) begin
            sel_valid = src_valid[j];
            sel_last  = src_last[j];
            sel_req   = req[j];
            sel_data  = src_byte[j];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TO_LOG2 =
      (TIMEOUT_CYCLES <= 2)       ? 1  : (TIMEOUT_CYCLES <= 4)       ? 2  :
      (TIMEOUT_CYCLES <= 16)      ? 4  : (TIMEOUT_CYCLES <= 64)      ? 6  :
      (TIMEOUT_CYCLES <= 256)     ? 8  : (TIMEOUT_CYCLES <= 1024)    ? 10 :
      (TIMEOUT_CYCLES <= 4096)    ? 12 : (TIMEOUT_CYCLES <= 16384)   ? 14 :
      (TIMEOUT_CYCLES <= 65536)   ? 16 : (TIMEOUT_CYCLES <= 262144)  ? 18 :
      (TIMEOUT_CYCLES <= 1048576) ? 20 : 24;
   localparam int TO_W = TO_LOG2 + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            tmo_q, tmo_d;
`endif

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      last_d     = last_q;
      data_d     = data_q;
      wb_cnt_d   = wb_cnt_q;
      start_d    = 1'b0;
      done_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_d      = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (found) begin
               gidx_d  = pick;
               grant_d = '0;
               for (int j = 0; j < NUM_REQ; j++) begin
                  if (IDX_W'(j) == pick) grant_d[j] = 1'b1;
               end
               byte_cnt_d = '0;
               state_d    = S_WAIT_BYTE;
            end
         end

         S_WAIT_BYTE: begin
            // A byte arriving together with a dropped req is still sent.
            if (sel_valid) begin
               data_d     = sel_data;
               last_d     = sel_last || (byte_cnt_q == CNT_LAST);
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               state_d    = S_START;
            end else if (!sel_req) begin
               grant_d    = '0;
               rr_ptr_d   = wrap_add(gidx_q, 1);
               byte_cnt_d = '0;
               state_d    = S_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               tmo_d      = 1'b1;
               grant_d    = '0;
               rr_ptr_d   = wrap_add(gidx_q, 1);
               byte_cnt_d = '0;
               state_d    = S_IDLE;
            end
`endif
         end

         S_START: begin
            // Holding here also covers a frame still running after reset.
            if (!uart_tx_busy) begin
               start_d  = 1'b1;
               wb_cnt_d = '0;
               state_d  = S_WAIT_BUSY;
            end
         end

         S_WAIT_BUSY: begin
            // A UART that never raises busy is assumed to have sent the
            // byte after four idle cycles.
            if (uart_tx_busy || (wb_cnt_q == 2'd3)) begin
               state_d = S_WAIT_DONE;
            end else begin
               wb_cnt_d = wb_cnt_q + 2'd1;
            end
         end

         S_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               if (last_q) begin
                  done_d     = 1'b1;
                  grant_d    = '0;
                  rr_ptr_d   = wrap_add(gidx_q, 1);
                  byte_cnt_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_WAIT_BYTE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      ready_d    = (state_d == S_WAIT_BYTE) ? grant_d : '0;
      arb_busy_d = |grant_d;

`ifdef ARB_TIMEOUT_EN
      // Counts cycles spent continuously in WAIT_BYTE; any exit or entry clears it.
      to_cnt_d = ((state_q == S_WAIT_BYTE) && (state_d == S_WAIT_BYTE)) ?
                 to_cnt_q + TO_W'(1) : '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         last_q     <= 1'b0;
         data_q     <= '0;
         wb_cnt_q   <= '0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= '0;
         arb_busy_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q   <= '0;
         tmo_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         last_q     <= last_d;
         data_q     <= data_d;
         wb_cnt_q   <= wb_cnt_d;
         start_q    <= start_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         arb_busy_q <= arb_busy_d;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

   assign grant         = grant_q;
   assign src_ready     = ready_q;
   assign uart_tx_start = start_q;
   assign uart_tx_data  = data_q;
   assign arb_busy      = arb_busy_q;
   assign pkt_done      = done_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout_pulse = tmo_q;
`else
   assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for uart_tx_arbiter.  Directed scenarios: reset, single packet,
// contention, abort, length cap, reset mid-frame and idle-source timeout.
// Byte sources and the UART are modelled in the step task; every input
// change happens 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   localparam int DW   = 8;
   localparam int NR   = 3;
   localparam int MAXB = 4;
   localparam int TOC  = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [NR-1:0]        req, src_valid, src_last, src_ready, grant;
   logic [NR*DW-1:0]     src_data;
   logic                 uart_tx_start;
   logic [DW-1:0]        uart_tx_data;
   logic                 uart_tx_busy;
   logic                 arb_busy, pkt_done, timeout_pulse;

   uart_tx_arbiter #(
      .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_PKT_BYTES(MAXB), .TIMEOUT_CYCLES(TOC)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_data(src_data),
      .src_last(src_last), .src_ready(src_ready), .grant(grant),
      .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
      .uart_tx_busy(uart_tx_busy), .arb_busy(arb_busy), .pkt_done(pkt_done),
      .timeout_pulse(timeout_pulse)
   );

   int checks = 0;
   int errors = 0;

   logic [8:0]    sq [NR][$];     // per-source {last, byte}
   logic [7:0]    uq [$];         // bytes started on the UART
   logic [NR-1:0] gq [$];         // sequence of new grants
   int            busy_cnt   = 0;
   bit            force_busy = 1'b0;
   bit            frame_valid = 1'b0;
   logic [7:0]    frame_byte = 8'h00;
   int            pd_cnt = 0, to_cnt = 0, start_cnt = 0, start_viol = 0;

   task automatic drive();
      logic [8:0] h;
      uart_tx_busy = force_busy || (busy_cnt != 0);
      for (int i = 0; i < NR; i++) begin
         h = (sq[i].size() != 0) ? sq[i][0] : 9'h000;
         src_valid[i]          = (sq[i].size() != 0);
         src_data[i*DW +: DW]  = h[7:0];
         src_last[i]           = h[8];
      end
   endtask

   task automatic step();
      logic [NR-1:0] g_prev;
      bit            took [NR];
      bit            st;
      g_prev = grant;
      for (int i = 0; i < NR; i++) took[i] = (src_ready[i] === 1'b1) && src_valid[i];
      st = 1'b0;
      if (uart_tx_start === 1'b1) begin
         if (uart_tx_busy) start_viol++;
         else begin
            st = 1'b1;
            start_cnt++;
            uq.push_back(uart_tx_data);
            frame_byte  = uart_tx_data;
            frame_valid = 1'b1;
         end
      end
      if (busy_cnt == 1 && frame_valid && !rst) begin
         checks++;
         if (uart_tx_data !== frame_byte) begin
            errors++;
            $display("FAIL data_stable: got %02h expected %02h", uart_tx_data, frame_byte);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (took[i]) void'(sq[i].pop_front());
      if (busy_cnt > 0) busy_cnt--;
      if (st) busy_cnt = 10;
      if (pkt_done === 1'b1) pd_cnt++;
      if (timeout_pulse === 1'b1) to_cnt++;
      if (grant !== '0 && grant !== g_prev) gq.push_back(grant);
      drive();
   endtask

   task automatic wait_pkt(input logic [NR-1:0] drop, input string nm);
      int n  = 0;
      int p0 = pd_cnt;
      while (pd_cnt == p0 && n < 400) begin step(); n++; end
      checks++;
      if (pd_cnt == p0) begin
         errors++;
         $display("FAIL %s_pkt_done: got no pulse within %0d cycles, required one", nm, n);
      end
      req = req & ~drop;
   endtask

   task automatic wait_uq(input int cnt, input string nm);
      int n = 0;
      while (uq.size() < cnt && n < 400) begin step(); n++; end
      checks++;
      if (uq.size() < cnt) begin
         errors++;
         $display("FAIL %s_bytes: got %0d bytes, required %0d", nm, uq.size(), cnt);
      end
   endtask

   task automatic wait_ready(input logic [NR-1:0] m, input string nm);
      int n = 0;
      while (src_ready !== m && n < 400) begin step(); n++; end
      checks++;
      if (src_ready !== m) begin
         errors++;
         $display("FAIL %s_ready: got %b, required %b", nm, src_ready, m);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      frame_valid = 1'b0;
      for (int i = 0; i < NR; i++) sq[i].delete();
      drive();
      step();
      step();
      rst = 1'b0;
      uq.delete();
      gq.delete();
      pd_cnt = 0; to_cnt = 0; start_cnt = 0; start_viol = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; force_busy = 1'b0;
      drive();
      step(); step();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
      checks++; if (src_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", src_ready); end
      checks++; if (uart_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", uart_tx_start); end
      checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", uart_tx_data); end
      checks++; if (arb_busy !== 1'b0 || pkt_done !== 1'b0 || timeout_pulse !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got busy=%b done=%b tmo=%b expected 0 0 0", arb_busy, pkt_done, timeout_pulse);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      sq[1].push_back({1'b0, 8'h41});
      sq[1].push_back({1'b0, 8'h42});
      sq[1].push_back({1'b1, 8'h43});
      req = 3'b010;
      drive();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_grant_early: got %b expected 000", grant); end
      step();
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", grant); end
      checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL single_arb_busy: got %b expected 1", arb_busy); end
      wait_pkt(3'b010, "single");
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_release: got %b expected 000", grant); end
      step(); step(); step();
      checks++; if (uq.size() != 3 || uq[0] !== 8'h41 || uq[1] !== 8'h42 || uq[2] !== 8'h43) begin
         errors++; $display("FAIL single_bytes: got %0d bytes, expected 41 42 43", uq.size());
      end
      checks++; if (start_cnt != 3 || start_viol != 0) begin
         errors++; $display("FAIL single_starts: got %0d starts %0d while busy, expected 3 and 0", start_cnt, start_viol);
      end
      checks++; if (pd_cnt != 1) begin errors++; $display("FAIL single_done_width: got %0d cycles, expected 1", pd_cnt); end
      $display("test_single done: %0d bytes", uq.size());
   endtask

   task automatic test_contention();
      do_reset();
      sq[0].push_back({1'b1, 8'hA0});
      sq[0].push_back({1'b1, 8'hA3});
      sq[1].push_back({1'b1, 8'hB1});
      sq[2].push_back({1'b1, 8'hC2});
      req = 3'b111;
      drive();
      wait_pkt(3'b000, "cont1");
      wait_pkt(3'b000, "cont2");
      wait_pkt(3'b000, "cont3");
      wait_pkt(3'b111, "cont4");
      step();
      checks++; if (gq.size() != 4 || gq[0] !== 3'b001 || gq[1] !== 3'b010 || gq[2] !== 3'b100 || gq[3] !== 3'b001) begin
         errors++; $display("FAIL cont_order: got %0d grants, expected 001 010 100 001", gq.size());
      end
      checks++; if (uq.size() != 4 || uq[0] !== 8'hA0 || uq[1] !== 8'hB1 || uq[2] !== 8'hC2 || uq[3] !== 8'hA3) begin
         errors++; $display("FAIL cont_bytes: got %0d bytes, expected A0 B1 C2 A3", uq.size());
      end
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL cont_idle: got %b expected 000", grant); end
      $display("test_contention done: %0d grants", gq.size());
   endtask

   task automatic test_abort();
      do_reset();
      sq[0].push_back({1'b0, 8'h55});
      sq[1].push_back({1'b1, 8'h66});
      req = 3'b011;
      drive();
      step();
      checks++; if (grant !== 3'b001) begin errors++; $display("FAIL abort_grant0: got %b expected 001", grant); end
      wait_uq(1, "abort");
      wait_ready(3'b001, "abort");
      req = 3'b010;
      step();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL abort_release: got %b expected 000", grant); end
      checks++; if (pd_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pd_cnt); end
      step();
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL abort_next: got %b expected 010", grant); end
      wait_pkt(3'b010, "abort");
      checks++; if (uq.size() != 2 || uq[0] !== 8'h55 || uq[1] !== 8'h66 || pd_cnt != 1) begin
         errors++; $display("FAIL abort_bytes: got %0d bytes %0d pulses, expected 55 66 and 1", uq.size(), pd_cnt);
      end
      $display("test_abort done");
   endtask

   task automatic test_length_cap();
      do_reset();
      for (int b = 0; b < 6; b++) sq[2].push_back({1'b0, 8'(8'h10 + b)});
      req = 3'b100;
      drive();
      wait_pkt(3'b000, "cap");
      checks++; if (uq.size() != 4 || uq[0] !== 8'h10 || uq[3] !== 8'h13) begin
         errors++; $display("FAIL cap_first: got %0d bytes, expected 10..13", uq.size());
      end
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL cap_release: got %b expected 000", grant); end
      step();
      checks++; if (grant !== 3'b100) begin errors++; $display("FAIL cap_regrant: got %b expected 100", grant); end
      wait_uq(6, "cap");
      wait_ready(3'b100, "cap");
      req = 3'b000;
      step(); step();
      checks++; if (grant !== 3'b000 || pd_cnt != 1) begin
         errors++; $display("FAIL cap_end: got grant %b pulses %0d, expected 000 and 1", grant, pd_cnt);
      end
      checks++; if (uq.size() != 6 || uq[4] !== 8'h14 || uq[5] !== 8'h15) begin
         errors++; $display("FAIL cap_rest: got %0d bytes, expected 14 15 at the end", uq.size());
      end
      $display("test_length_cap done: %0d bytes", uq.size());
   endtask

   task automatic test_reset_mid();
      do_reset();
      sq[0].push_back({1'b0, 8'h77});
      sq[0].push_back({1'b1, 8'h78});
      req = 3'b001;
      drive();
      wait_uq(1, "rmid");
      step(); step(); step();
      rst = 1'b1; force_busy = 1'b1; frame_valid = 1'b0; req = 3'b000;
      sq[0].delete();
      drive();
      step();
      checks++; if (grant !== 3'b000 || src_ready !== 3'b000 || arb_busy !== 1'b0) begin
         errors++; $display("FAIL rmid_outputs: got grant %b ready %b busy %b, expected 000 000 0", grant, src_ready, arb_busy);
      end
      checks++; if (uart_tx_start !== 1'b0 || pkt_done !== 1'b0 || uart_tx_data !== 8'h00) begin
         errors++; $display("FAIL rmid_uart: got start %b done %b data %02h, expected 0 0 00", uart_tx_start, pkt_done, uart_tx_data);
      end
      rst = 1'b0;
      sq[1].push_back({1'b1, 8'h99});
      req = 3'b010;
      drive();
      step();
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL rmid_grant: got %b expected 010", grant); end
      repeat (20) step();
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL rmid_withheld: got %0d starts expected 1", start_cnt); end
      force_busy = 1'b0;
      drive();
      wait_pkt(3'b010, "rmid");
      checks++; if (uq.size() != 2 || uq[1] !== 8'h99 || start_viol != 0) begin
         errors++; $display("FAIL rmid_send: got %0d bytes %0d busy starts, expected 99 last and 0", uq.size(), start_viol);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      req = 3'b010;
      drive();
      step();
      checks++; if (grant !== 3'b010) begin errors++; $display("FAIL tmo_grant: got %b expected 010", grant); end
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (to_cnt == 0 && n < 60) begin step(); n++; end
      req = 3'b000;
      checks++; if (n != TOC) begin errors++; $display("FAIL tmo_cycle: got pulse after %0d cycles expected %0d", n, TOC); end
      checks++; if (grant !== 3'b000 || pd_cnt != 0) begin
         errors++; $display("FAIL tmo_release: got grant %b pulses %0d expected 000 and 0", grant, pd_cnt);
      end
      step();
      checks++; if (to_cnt != 1) begin errors++; $display("FAIL tmo_width: got %0d cycles expected 1", to_cnt); end
`else
      n = 0;
      repeat (100) begin step(); n++; end
      checks++; if (grant !== 3'b010 || to_cnt != 0) begin
         errors++; $display("FAIL tmo_hold: got grant %b pulses %0d after %0d cycles, expected 010 and 0", grant, to_cnt, n);
      end
      req = 3'b000;
      step();
      checks++; if (grant !== 3'b000) begin errors++; $display("FAIL tmo_drop: got %b expected 000", grant); end
`endif
      $display("test_timeout done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_abort();
      test_length_cap();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter among NUM_REQ byte-stream sources: traverse/dump bridge, prompt/menu text, compute-result printer.
- Packet-level round-robin arbitration: a source keeps the UART until its last byte finishes, then priority rotates.
- Sits between the byte sources and uart_tx.
- Drives uart_tx's tx_start/tx_data and watches tx_busy.

Parameters:
- DATA_WIDTH, 8, byte width to UART
- NUM_REQ, 3, number of requesters (2..4)
- MAX_PKT_BYTES, 64, byte limit per grant; reaching it force-ends the packet
- TIMEOUT_CYCLES, 100000, idle-source timeout (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-source packet request, held for the whole packet
- src_valid  in  NUM_REQ  per-source byte valid
- src_data  in  NUM_REQ*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_last  in  NUM_REQ  byte is the final byte of the packet
- src_ready  out  NUM_REQ  one-hot byte accept for the granted source
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- uart_tx_start  out  1  one-cycle start pulse to uart_tx
- uart_tx_data  out  DATA_WIDTH  byte to uart_tx; stable from start until busy falls
- uart_tx_busy  in  1  uart_tx busy
- arb_busy  out  1  grant != 0
- pkt_done  out  1  one-cycle pulse after the last byte of a packet completes on the line
- timeout_pulse  out  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only, else 0)

Behaviour:
- Reset: all outputs 0; rr_ptr=0; byte_cnt=0; state IDLE. Reset mid-packet abandons the packet.
- States: IDLE, WAIT_BYTE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: search req from rr_ptr upward, wrapping modulo NUM_REQ. The first set bit g is registered into grant and the FSM goes to WAIT_BYTE. Latency: req high in cycle N gives grant in N+1. No req means stay in IDLE.
- WAIT_BYTE:
  - src_ready[g]=1; all other src_ready bits 0.
  - Accept on src_valid[g]: latch the data slice into uart_tx_data, latch last_q = src_last[g] OR (byte_cnt == MAX_PKT_BYTES-1), byte_cnt++, go to START.
  - Else, if req[g]==0: release. grant=0, rr_ptr=(g+1)%NUM_REQ, byte_cnt=0, go to IDLE. No pkt_done.
  - If valid and a dropped req occur in the same cycle, valid wins.
- START:
  - If uart_tx_busy==0: uart_tx_start=1 for exactly this cycle, go to WAIT_BUSY.
  - Otherwise hold in START with uart_tx_start=0. This covers a frame still running after reset.
- WAIT_BUSY: wait for uart_tx_busy==1, then go to WAIT_DONE. If busy stays 0 for 4 cycles, treat the byte as already sent and go to WAIT_DONE.
- WAIT_DONE: on uart_tx_busy==0:
  - last_q=1: pkt_done=1 for one cycle, grant=0, rr_ptr=(g+1)%NUM_REQ, byte_cnt=0, go to IDLE.
  - last_q=0: go back to WAIT_BYTE.
- src_ready is 0 in every state except WAIT_BYTE, so at most one byte is in flight.
- Requests from non-granted sources are ignored until IDLE. Round-robin guarantees every source a grant within NUM_REQ packets.
- byte_cnt width is clog2(MAX_PKT_BYTES)+1, hand-computed by localparam ladder. It never exceeds MAX_PKT_BYTES.
- arb_busy = |grant, registered together with grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BYTE and clears on every byte accept and on state entry.
  - At TIMEOUT_CYCLES with no src_valid[g]: timeout_pulse=1 for one cycle, grant released as if req dropped (rr_ptr advances), go to IDLE, no pkt_done.
- Undefined: no counter logic; timeout_pulse tied 0; a stalled source holds the UART until it drops req.

Test Plan:
- Single packet: req[1]=1, 3 bytes 0x41,0x42,0x43, last on 0x43, uart model busy 10 cycles -> grant=3'b010 one cycle after req; three uart_tx_start pulses each after busy falls; pkt_done pulse; grant=0.
- Contention: req=3'b111 held, each source sends a 1-byte packet -> grants in order 001, 010, 100, 001; no source granted twice in a row while others request.
- Abort: grant to source 0, 1 byte sent without last, then req[0] drops -> grant=0 after WAIT_DONE/WAIT_BYTE, no pkt_done, next grant goes to source 1.
- Length cap: MAX_PKT_BYTES=4, source 2 streams 6 bytes without last -> exactly 4 bytes sent, pkt_done after the 4th, source 2 regranted later for the remainder.
- Reset mid-frame: rst asserted while uart_tx_busy=1 in WAIT_DONE -> all outputs 0 next cycle; after rst, a new req is granted but uart_tx_start is withheld until uart_tx_busy=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): grant source 1 with no valid -> timeout_pulse on cycle 20 of WAIT_BYTE, grant=0; same bench without the macro -> grant held at 100 cycles.
